// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: two-entry skid buffer stage with registered in_ready, flush and saturating stall counter
module pipe_skid_stage #(
   parameter int               DATA_W = 32,
   parameter int               IR_W   = 32,
   parameter logic [IR_W-1:0]  NOP_IR = '0,
   parameter int               CNT_W  = 16
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_o,
   input  logic [DATA_W-1:0] in_d,
   input  logic [IR_W-1:0]   in_ir,
   input  logic              in_ovf,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_o,
   output logic [DATA_W-1:0] out_d,
   output logic [IR_W-1:0]   out_ir,
   output logic              out_ovf,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);
   typedef struct packed {
      logic [DATA_W-1:0] o;
      logic [DATA_W-1:0] d;
      logic [IR_W-1:0]   ir;
      logic              ovf;
   } ent_t;
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
   state_t           state_q, state_d;
   ent_t             main_q, main_d, skid_q, skid_d, in_e;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic             acc, con;
   assign in_e      = {in_o, in_d, in_ir, in_ovf};
   assign out_valid = state_q != EMPTY;
   assign in_ready  = state_q != FULL;
   assign occupancy = state_q;
   assign acc       = in_valid && in_ready;
   assign con       = out_valid && out_ready;
   assign out_o     = out_valid ? main_q.o : '0;
   assign out_d     = out_valid ? main_q.d : '0;
   assign out_ir    = out_valid ? main_q.ir : NOP_IR;
   assign out_ovf   = out_valid && main_q.ovf;
   assign stall_cnt = stall_q;
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      stall_d = (out_valid && !out_ready && stall_q != '1) ? stall_q + CNT_W'(1) : stall_q;
      if (flush) state_d = EMPTY;
      else case (state_q)
         EMPTY: if (acc) begin
            main_d  = in_e;
            state_d = ONE;
         end
         ONE: if (con && acc) main_d = in_e;
         else if (con) state_d = EMPTY;
         else if (acc) begin
            skid_d  = in_e;
            state_d = FULL;
         end
         FULL: if (con) begin
            main_d  = skid_q;
            state_d = ONE;
         end
         default: state_d = EMPTY;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!clr) begin
         state_q <= EMPTY;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         stall_q <= stall_d;
      end
   end
   // payload registers need no reset: out_valid masks them to the bubble
   always_ff @(posedge clk) begin
      main_q <= main_d;
      skid_q <= skid_d;
   end
endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: directed stimulus with a scoreboard queue and a decoupled output monitor
module tb_pipe_skid_stage;
   localparam int              DW  = 32;
   localparam int              IW  = 32;
   localparam int              CW  = 4;
   localparam logic [IW-1:0]   NOP = 32'hDEAD_0013;
   localparam int              EW  = 2 * DW + IW + 1;

   logic          clk = 1'b0;
   logic          clr, in_valid, in_ready, in_ovf, flush, out_valid, out_ready, out_ovf;
   logic [DW-1:0] in_o, in_d, out_o, out_d;
   logic [IW-1:0] in_ir, out_ir;
   logic [1:0]    occupancy;
   logic [CW-1:0] stall_cnt;
   logic [EW-1:0] sb[$];
   logic [EW-1:0] exp_e;
   int            n_chk = 0;
   int            n_fail = 0;

   pipe_skid_stage #(.DATA_W(DW), .IR_W(IW), .NOP_IR(NOP), .CNT_W(CW)) dut (
      .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
      .in_o(in_o), .in_d(in_d), .in_ir(in_ir), .in_ovf(in_ovf), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_o(out_o), .out_d(out_d),
      .out_ir(out_ir), .out_ovf(out_ovf), .occupancy(occupancy), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DW-1:0] o, input logic [IW-1:0] ir, input logic ovf);
      in_valid = 1'b1;
      in_o     = o;
      in_d     = o + 32'h100;
      in_ir    = ir;
      in_ovf   = ovf;
   endtask

   // Monitor/scoreboard: entries accepted this edge are queued; consumed entries are popped and compared.
   always @(negedge clk) begin
      if (!clr || flush) sb.delete();
      else begin
         if (out_valid && out_ready) begin
            n_chk++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_output: got o=%0h ir=%0h expected none", out_o, out_ir);
            end else begin
               exp_e = sb.pop_front();
               if ({out_o, out_d, out_ir, out_ovf} !== exp_e) begin
                  n_fail++;
                  $display("FAIL scoreboard: got %0h expected %0h", {out_o, out_d, out_ir, out_ovf}, exp_e);
               end
            end
         end
         if (in_valid && in_ready) sb.push_back({in_o, in_d, in_ir, in_ovf});
      end
   end

   initial begin
      clr = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      in_o = '0; in_d = '0; in_ir = '0; in_ovf = 1'b0;
      step(); step();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_occ", occupancy, 0);
      chk("rst_stall", stall_cnt, 0);
      chk("rst_bubble_ir", out_ir, NOP);
      chk("rst_bubble_o", out_o, 0);
      chk("rst_in_ready", in_ready, 1);
      clr = 1'b1;
      step();
      // single entry, next-cycle latency
      send(32'h11, 32'hAA, 1'b1);
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk("lat_valid", out_valid, 1);
      chk("lat_o", out_o, 32'h11);
      chk("lat_ir", out_ir, 32'hAA);
      chk("lat_occ", occupancy, 1);
      step();
      chk("lat_drain_occ", occupancy, 0);
      // fill to FULL with backpressure, then hold
      out_ready = 1'b0;
      send(32'h1, 32'h101, 1'b0);
      step();
      chk("fill_occ1", occupancy, 1);
      send(32'h2, 32'h102, 1'b1);
      step();
      chk("full_in_ready", in_ready, 0);
      chk("full_occ", occupancy, 2);
      chk("full_stall", stall_cnt, 1);
      send(32'h3, 32'h103, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("hold_o", out_o, 32'h1);
         chk("hold_in_ready", in_ready, 0);
      end
      chk("hold_stall", stall_cnt, 6);
      out_ready = 1'b1;
      step();
      chk("drain_b", out_o, 32'h2);
      step();
      in_valid = 1'b0;
      chk("drain_c", out_o, 32'h3);
      step();
      chk("drain_occ", occupancy, 0);
      chk("drain_stall", stall_cnt, 6);
      // flush while FULL with a simultaneous input
      out_ready = 1'b0;
      send(32'h4, 32'h104, 1'b0);
      step();
      send(32'h5, 32'h105, 1'b1);
      step();
      send(32'h6, 32'h106, 1'b1);
      flush = 1'b1;
      #1;
      chk("flush_cycle_in_ready", in_ready, 0);
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush_occ", occupancy, 0);
      chk("flush_valid", out_valid, 0);
      chk("flush_ir", out_ir, NOP);
      chk("flush_in_ready", in_ready, 1);
      out_ready = 1'b1;
      send(32'h7, 32'h107, 1'b0);
      step();
      in_valid = 1'b0;
      chk("post_flush_o", out_o, 32'h7);
      step();
      // saturation of the stall counter
      out_ready = 1'b0;
      send(32'h8, 32'h108, 1'b0);
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 20; i++) step();
      chk("sat_stall", stall_cnt, 15);
      step(); step(); step();
      chk("sat_hold", stall_cnt, 15);
      // reset while FULL drops both entries
      send(32'h9, 32'h109, 1'b1);
      step();
      in_valid = 1'b0;
      chk("pre_rst_occ", occupancy, 2);
      clr = 1'b0;
      out_ready = 1'b1;
      step();
      clr = 1'b1;
      chk("mid_rst_occ", occupancy, 0);
      chk("mid_rst_stall", stall_cnt, 0);
      chk("mid_rst_valid", out_valid, 0);
      step(); step();
      chk("mid_rst_quiet", out_valid, 0);
      send(32'hA, 32'h10A, 1'b1);
      step();
      in_valid = 1'b0;
      chk("final_o", out_o, 32'hA);
      step(); step();
      chk("sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
